// File: rtl/fphub_special_pkg.sv
// rtl/fphub_special_pkg.sv - shared class codes and bit patterns for the special-case resolver
package fphub_special_pkg;

    localparam int CODE_W = 3;

    // Widest magnitude field the pattern constants cover; operands slice from the LSB end.
    localparam int PAT_MAX_W = 64;

    localparam logic [PAT_MAX_W-1:0] PAT_INF  = {PAT_MAX_W{1'b1}};
    localparam logic [PAT_MAX_W-1:0] PAT_ZERO = {PAT_MAX_W{1'b0}};

    typedef enum logic [CODE_W-1:0] {
        CASE_NONE   = 3'd0,
        CASE_INF_P  = 3'd1,
        CASE_INF_N  = 3'd2,
        CASE_ZERO_P = 3'd3,
        CASE_ZERO_N = 3'd4,
        CASE_ONE_P  = 3'd5,
        CASE_ONE_N  = 3'd6
    } case_code_e;

    function automatic logic is_inf(input logic [CODE_W-1:0] c);
        return (c == CASE_INF_P) || (c == CASE_INF_N);
    endfunction

    function automatic logic is_zero(input logic [CODE_W-1:0] c);
        return (c == CASE_ZERO_P) || (c == CASE_ZERO_N);
    endfunction

    function automatic logic is_one(input logic [CODE_W-1:0] c);
        return (c == CASE_ONE_P) || (c == CASE_ONE_N);
    endfunction

endpackage

// File: rtl/special_case_classify.sv
// rtl/special_case_classify.sv - combinational class-code decode of one operand
module special_case_classify
    import fphub_special_pkg::*;
#(
    parameter int M = 23,
    parameter int E = 8
) (
    input  logic [E+M:0]        op,
    output logic [CODE_W-1:0]   code
);

    localparam int W = E + M + 1;

    // ONE means a biased exponent of exactly 2^(E-1) with an empty mantissa.
    localparam logic [W-2:0] ONE_PAT = {1'b1, PAT_ZERO[W-3:0]};

    logic         sign;
    logic [W-2:0] mag;

    assign sign = op[W-1];
    assign mag  = op[W-2:0];

    // Decode magnitude pattern first, then let the sign pick the negative code.
    always_comb begin
        code = CASE_NONE;
        if (mag == PAT_INF[W-2:0]) begin
            code = sign ? CASE_INF_N : CASE_INF_P;
        end else if (mag == PAT_ZERO[W-2:0]) begin
            code = sign ? CASE_ZERO_N : CASE_ZERO_P;
        end else if (mag == ONE_PAT) begin
            code = sign ? CASE_ONE_N : CASE_ONE_P;
        end
    end

endmodule

// File: rtl/special_case_resolver.sv
// rtl/special_case_resolver.sv - multi-lane divide special-case resolver with stallable pipeline
module special_case_resolver
    import fphub_special_pkg::*;
#(
    parameter int M     = 23,
    parameter int E     = 8,
    parameter int LANES = 1,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic                        clk,
    input  logic                        rst_l,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [LANES*(E+M+1)-1:0]    X,
    input  logic [LANES*(E+M+1)-1:0]    Y,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*3-1:0]          X_case,
    output logic [LANES*3-1:0]          Y_case,
    output logic [LANES-1:0]            res_special,
    output logic [LANES*(E+M+1)-1:0]    res_value,
    input  logic                        clear_count,
    output logic [CNT_W-1:0]            special_count
);

    localparam int W     = E + M + 1;
    localparam int SUM_W = CNT_W + 4;

    logic [LANES*CODE_W-1:0] xc_comb;
    logic [LANES*CODE_W-1:0] yc_comb;
    logic [LANES-1:0]        sp_comb;
    logic [LANES*W-1:0]      val_comb;

    logic [DEPTH-1:0]        st_valid;
    logic [LANES*CODE_W-1:0] st_xc  [DEPTH];
    logic [LANES*CODE_W-1:0] st_yc  [DEPTH];
    logic [LANES-1:0]        st_sp  [DEPTH];
    logic [LANES*W-1:0]      st_val [DEPTH];

    logic [3:0]              pop;
    logic [SUM_W-1:0]        sum;
    logic [CNT_W-1:0]        cnt_next;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            special_case_classify #(.M(M), .E(E)) u_cls_x (
                .op   (X[g*W +: W]),
                .code (xc_comb[g*CODE_W +: CODE_W])
            );
            special_case_classify #(.M(M), .E(E)) u_cls_y (
                .op   (Y[g*W +: W]),
                .code (yc_comb[g*CODE_W +: CODE_W])
            );
        end
    endgenerate

    // Per-lane quotient resolution in priority order: NaN-ish/inf first, then zero, then divide-by-one.
    always_comb begin
        logic                s;
        logic [CODE_W-1:0]   xc;
        logic [CODE_W-1:0]   yc;
        sp_comb  = '0;
        val_comb = '0;
        s        = 1'b0;
        xc       = '0;
        yc       = '0;
        for (int l = 0; l < LANES; l++) begin
            s  = X[l*W + W - 1] ^ Y[l*W + W - 1];
            xc = xc_comb[l*CODE_W +: CODE_W];
            yc = yc_comb[l*CODE_W +: CODE_W];
            if (is_inf(xc) || is_zero(yc)) begin
                sp_comb[l]          = 1'b1;
                val_comb[l*W +: W]  = {s, PAT_INF[W-2:0]};
            end else if (is_zero(xc) || is_inf(yc)) begin
                sp_comb[l]          = 1'b1;
                val_comb[l*W +: W]  = {s, PAT_ZERO[W-2:0]};
            end else if (is_one(yc)) begin
                sp_comb[l]          = 1'b1;
                val_comb[l*W +: W]  = {s, X[l*W +: W-1]};
            end
        end
    end

    // The whole pipe moves as one; a stalled output freezes every stage, bubbles included.
    assign in_ready    = ~(out_valid & ~out_ready);

    assign out_valid   = st_valid[DEPTH-1];
    assign X_case      = st_xc[DEPTH-1];
    assign Y_case      = st_yc[DEPTH-1];
    assign res_special = st_sp[DEPTH-1];
    assign res_value   = st_val[DEPTH-1];

    // Pipeline stages: reset discards everything in flight, otherwise shift when not stalled.
    always_ff @(posedge clk or posedge rst_l) begin
        if (rst_l) begin
            st_valid <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                st_xc[s]  <= '0;
                st_yc[s]  <= '0;
                st_sp[s]  <= '0;
                st_val[s] <= '0;
            end
        end else if (in_ready) begin
            st_valid[0] <= in_valid;
            st_xc[0]    <= xc_comb;
            st_yc[0]    <= yc_comb;
            st_sp[0]    <= sp_comb;
            st_val[0]   <= val_comb;
            for (int s = 1; s < DEPTH; s++) begin
                st_valid[s] <= st_valid[s-1];
                st_xc[s]    <= st_xc[s-1];
                st_yc[s]    <= st_yc[s-1];
                st_sp[s]    <= st_sp[s-1];
                st_val[s]   <= st_val[s-1];
            end
        end
    end

    // Number of special lanes in the bundle at the output, added with saturation.
    always_comb begin
        pop = '0;
        for (int l = 0; l < LANES; l++) begin
            pop = pop + {3'b000, res_special[l]};
        end
        sum      = {4'b0000, special_count} + {{CNT_W{1'b0}}, pop};
        cnt_next = (sum[SUM_W-1:CNT_W] != 4'b0000) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    // Special-lane event counter; a clear in the same cycle as a delivery wins.
    always_ff @(posedge clk or posedge rst_l) begin
        if (rst_l) begin
            special_count <= '0;
        end else if (clear_count) begin
            special_count <= '0;
        end else if (out_valid && out_ready) begin
            special_count <= cnt_next;
        end
    end

endmodule

// File: tb/tb_special_case_resolver.sv
// tb/tb_special_case_resolver.sv - directed and randomized self-checking bench for special_case_resolver
module tb_special_case_resolver;

    localparam int M = 23;
    localparam int E = 8;
    localparam int LANES = 2;
    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    typedef struct packed {
        logic [5:0]  xc;
        logic [5:0]  yc;
        logic [1:0]  sp;
        logic [63:0] val;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] X;
    logic [63:0] Y;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  X_case;
    logic [5:0]  Y_case;
    logic [1:0]  res_special;
    logic [63:0] res_value;
    logic        clear_count;
    logic [15:0] special_count;

    int errors = 0;
    int checks = 0;

    bundle_t q[$];

    special_case_resolver #(
        .M(M), .E(E), .LANES(LANES), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .X             (X),
        .Y             (Y),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .X_case        (X_case),
        .Y_case        (Y_case),
        .res_special   (res_special),
        .res_value     (res_value),
        .clear_count   (clear_count),
        .special_count (special_count)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ref_class(input logic [31:0] op);
        if (op[30:0] == 31'h7FFFFFFF) return op[31] ? 3'd2 : 3'd1;
        if (op[30:0] == 31'h00000000) return op[31] ? 3'd4 : 3'd3;
        if (op[30:0] == 31'h40000000) return op[31] ? 3'd6 : 3'd5;
        return 3'd0;
    endfunction

    function automatic bundle_t ref_bundle(input logic [63:0] x, input logic [63:0] y);
        bundle_t r;
        logic [31:0] xo;
        logic [31:0] yo;
        logic [2:0] cx;
        logic [2:0] cy;
        logic s;
        r = '0;
        for (int l = 0; l < 2; l++) begin
            xo = x[l*32 +: 32];
            yo = y[l*32 +: 32];
            cx = ref_class(xo);
            cy = ref_class(yo);
            s  = xo[31] ^ yo[31];
            r.xc[l*3 +: 3] = cx;
            r.yc[l*3 +: 3] = cy;
            if (cx == 3'd1 || cx == 3'd2 || cy == 3'd3 || cy == 3'd4) begin
                r.sp[l] = 1'b1;
                r.val[l*32 +: 32] = {s, 31'h7FFFFFFF};
            end else if (cx == 3'd3 || cx == 3'd4 || cy == 3'd1 || cy == 3'd2) begin
                r.sp[l] = 1'b1;
                r.val[l*32 +: 32] = {s, 31'h00000000};
            end else if (cy == 3'd5 || cy == 3'd6) begin
                r.sp[l] = 1'b1;
                r.val[l*32 +: 32] = {s, xo[30:0]};
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 5))
            0: v[30:0] = 31'h7FFFFFFF;
            1: v[30:0] = 31'h00000000;
            2: v[30:0] = 31'h40000000;
            default: ;
        endcase
        return v;
    endfunction

    task automatic send_one(input logic [63:0] x, input logic [63:0] y);
        X = x;
        Y = y;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_l = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        clear_count = 1'b0;
        X = '0;
        Y = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_l = 1'b0;
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (special_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %h expected 0000", special_count); end
    endtask

    task automatic test_directed();
        logic [77:0] obs;
        out_ready = 1'b1;
        // bundle A: lane0 1.5 / -2.0, lane1 inf / +0
        send_one({32'h7FFFFFFF, 32'h3FC00000}, {32'h00000000, 32'hC0000000});
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_early: got %b expected 0", out_valid); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL latency_two: got %b expected 1", out_valid); end
        obs = {X_case, Y_case, res_special, res_value};
        checks++;
        if (obs !== {6'b001_000, 6'b011_110, 2'b11, 32'h7FFFFFFF, 32'hBFC00000}) begin
            errors++; $display("FAIL bundle_a: got %h expected %h", obs, {6'b001_000, 6'b011_110, 2'b11, 32'h7FFFFFFF, 32'hBFC00000});
        end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_delivery: got %b expected 0", out_valid); end
        // bundle B: lane0 1.0 / 2.0 (divide by one), lane1 -0 / inf
        send_one({32'h80000000, 32'h3F800000}, {32'h7FFFFFFF, 32'h40000000});
        @(posedge clk); #1;
        obs = {X_case, Y_case, res_special, res_value};
        checks++;
        if (out_valid !== 1'b1 || obs !== {6'b100_000, 6'b001_101, 2'b11, 32'h80000000, 32'h3F800000}) begin
            errors++; $display("FAIL bundle_b: got v=%b %h expected v=1 %h", out_valid, obs, {6'b100_000, 6'b001_101, 2'b11, 32'h80000000, 32'h3F800000});
        end
        @(posedge clk); #1;
        // bundle C: lane0 X is ONE but Y plain (not special), lane1 0/0
        send_one({32'h00000000, 32'h40000000}, {32'h00000000, 32'h40400000});
        @(posedge clk); #1;
        obs = {X_case, Y_case, res_special, res_value};
        checks++;
        if (out_valid !== 1'b1 || obs !== {6'b011_101, 6'b011_000, 2'b10, 32'h7FFFFFFF, 32'h00000000}) begin
            errors++; $display("FAIL bundle_c: got v=%b %h expected v=1 %h", out_valid, obs, {6'b011_101, 6'b011_000, 2'b10, 32'h7FFFFFFF, 32'h00000000});
        end
        @(posedge clk); #1;
        checks++; if (special_count !== 16'd5) begin errors++; $display("FAIL count_directed: got %0d expected 5", special_count); end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        int sent = 0;
        int delivered = 0;
        logic prev_stall = 1'b0;
        logic [77:0] snap = '0;
        logic [77:0] obs;
        bundle_t exp_b;
        q.delete();
        while (delivered < 6 && k < 60) begin
            if (sent < 6) begin
                in_valid = 1'b1;
                X = {32'h00800000 * sent, 32'h3FC00000 + sent};
                Y = {32'h7FFFFFFF, 32'hC0000000};
            end else begin
                in_valid = 1'b0;
            end
            out_ready = !(k >= 3 && k <= 7);
            #1;
            obs = {X_case, Y_case, res_special, res_value};
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || obs !== snap) begin
                    errors++; $display("FAIL b2b_hold: got v=%b %h expected v=1 %h", out_valid, obs, snap);
                end
            end
            if (out_valid && !out_ready) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_in_ready: got %b expected 0", in_ready); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra: got unexpected bundle %h expected none", obs);
                end else begin
                    exp_b = q.pop_front();
                    if (obs !== exp_b) begin errors++; $display("FAIL b2b_data: got %h expected %h", obs, exp_b); end
                end
                delivered++;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_bundle(X, Y));
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            snap = obs;
            @(posedge clk); #1;
            k++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (delivered != 6 || q.size() != 0) begin
            errors++; $display("FAIL b2b_total: got delivered=%0d left=%0d expected 6 and 0", delivered, q.size());
        end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_counter_sat();
        out_ready = 1'b1;
        clear_count = 1'b1;
        @(posedge clk); #1;
        clear_count = 1'b0;
        checks++; if (special_count !== 16'h0) begin errors++; $display("FAIL count_clear: got %h expected 0000", special_count); end
        X = {32'h7FFFFFFF, 32'hFFFFFFFF};
        Y = {32'h3F800000, 32'h3F800000};
        in_valid = 1'b1;
        repeat (32767) @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (special_count !== 16'hFFFE) begin errors++; $display("FAIL count_preset: got %h expected fffe", special_count); end
        send_one({32'h7FFFFFFF, 32'h7FFFFFFF}, {32'h3F800000, 32'h3F800000});
        repeat (2) @(posedge clk);
        #1;
        checks++; if (special_count !== 16'hFFFF) begin errors++; $display("FAIL count_saturate: got %h expected ffff", special_count); end
        send_one({32'h7FFFFFFF, 32'h7FFFFFFF}, {32'h3F800000, 32'h3F800000});
        repeat (2) @(posedge clk);
        #1;
        checks++; if (special_count !== 16'hFFFF) begin errors++; $display("FAIL count_hold_sat: got %h expected ffff", special_count); end
        send_one({32'h7FFFFFFF, 32'h7FFFFFFF}, {32'h3F800000, 32'h3F800000});
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clear_setup: got %b expected 1", out_valid); end
        clear_count = 1'b1;
        @(posedge clk); #1;
        clear_count = 1'b0;
        checks++; if (special_count !== 16'h0) begin errors++; $display("FAIL clear_wins: got %h expected 0000", special_count); end
    endtask

    task automatic test_reset_midstream();
        int stale = 0;
        out_ready = 1'b1;
        X = {32'h7FFFFFFF, 32'h7FFFFFFF};
        Y = {32'h3F800000, 32'h3F800000};
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || special_count !== 16'd2) begin
            errors++; $display("FAIL midrst_setup: got v=%b cnt=%0d expected v=1 cnt=2", out_valid, special_count);
        end
        #2;
        rst_l = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        checks++; if (special_count !== 16'h0) begin errors++; $display("FAIL midrst_count: got %h expected 0000", special_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        #2;
        rst_l = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) stale++;
        end
        checks++; if (stale != 0) begin errors++; $display("FAIL midrst_stale: got %0d bundles expected 0", stale); end
    endtask

    task automatic test_random();
        int cyc = 0;
        int acc = 0;
        int delivered = 0;
        int bad = 0;
        logic prev_stall = 1'b0;
        logic [77:0] snap = '0;
        logic [77:0] obs;
        bundle_t exp_b;
        q.delete();
        while (delivered < 10000 && cyc < 40000) begin
            X = {rnd_op(), rnd_op()};
            Y = {rnd_op(), rnd_op()};
            in_valid = (acc < 10000) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            obs = {X_case, Y_case, res_special, res_value};
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || obs !== snap) begin
                    errors++;
                    if (bad < 10) $display("FAIL rnd_hold: got v=%b %h expected v=1 %h", out_valid, obs, snap);
                    bad++;
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    if (bad < 10) $display("FAIL rnd_extra: got %h expected none", obs);
                    bad++;
                end else begin
                    exp_b = q.pop_front();
                    if (obs !== exp_b) begin
                        errors++;
                        if (bad < 10) $display("FAIL rnd_data: got %h expected %h", obs, exp_b);
                        bad++;
                    end
                end
                delivered++;
            end
            if (in_valid && in_ready) begin
                q.push_back(ref_bundle(X, Y));
                acc++;
            end
            prev_stall = out_valid && !out_ready;
            snap = obs;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (delivered != 10000 || q.size() != 0) begin
            errors++; $display("FAIL rnd_total: got delivered=%0d left=%0d expected 10000 and 0", delivered, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_counter_sat();
        test_reset_midstream();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
